// File: rtl/ddc_pkg.sv
// Shared constants, types and the mixer product slicer for the DDC mixer/CIC block.
package ddc_pkg;

    localparam int unsigned DW    = 14;
    localparam int unsigned MPR   = 14;
    localparam int unsigned MW    = 16;
    localparam int unsigned R     = 8;
    localparam int unsigned LOG2R = 3;
    localparam int unsigned NS    = 3;
    localparam int unsigned AW    = MW + NS * LOG2R;
    localparam int unsigned OW    = 16;
    localparam int unsigned PW    = DW + MPR;

    typedef logic signed [DW-1:0]    sample_t;
    typedef logic signed [MPR-1:0]   nco_t;
    typedef logic signed [MW-1:0]    mix_t;
    typedef logic signed [AW-1:0]    acc_t;
    typedef logic signed [OW-1:0]    out_t;
    typedef logic signed [PW-1:0]    prod_t;
    typedef logic        [LOG2R-1:0] cnt_t;

    localparam mix_t MIX_MAX = {1'b0, {(MW-1){1'b1}}};
    localparam mix_t MIX_MIN = {1'b1, {(MW-1){1'b0}}};

    // Take product bits [PW-2 -: MW]; clamp when the two top bits disagree
    // (only +2^26, from -8192 * -8192, can reach that in practice).
    function automatic mix_t sat_mix(input prod_t p);
        mix_t r;
        if (p[PW-1] != p[PW-2]) begin
            r = p[PW-1] ? MIX_MIN : MIX_MAX;
        end else begin
            r = mix_t'(p[PW-2 -: MW]);
        end
        return r;
    endfunction

endpackage

// File: rtl/ddc_cic_chain.sv
// One rail of the CIC decimator: NS integrators, decimated sample register,
// NS combs (M=1) and the truncating output register.
module ddc_cic_chain
    import ddc_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clken,
    input  logic signed [MW-1:0] mix,
    input  logic [NS-1:0]        int_v,
    input  logic [NS+1:0]        dec_v,
    output logic signed [OW-1:0] dout
);

    acc_t integ    [NS];
    acc_t integ_in [NS];
    acc_t dsamp;
    acc_t comb     [NS];
    acc_t comb_in  [NS];
    acc_t dly      [NS];

    // Stage input selection: sign-extended mix feeds I1, dsamp feeds C1.
    always_comb begin
        integ_in[0] = AW'(mix);
        comb_in[0]  = dsamp;
        for (int k = 1; k < NS; k++) begin
            integ_in[k] = integ[k-1];
            comb_in[k]  = comb[k-1];
        end
    end

    // Integrators: wrap-around accumulation, each gated by its stage valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NS; k++) begin
                integ[k] <= '0;
            end
        end else if (clken) begin
            for (int k = 0; k < NS; k++) begin
                if (int_v[k]) begin
                    integ[k] <= integ[k] + integ_in[k];
                end
            end
        end
    end

    // Decimated capture of the last integrator, then the comb sections.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dsamp <= '0;
            for (int k = 0; k < NS; k++) begin
                comb[k] <= '0;
                dly[k]  <= '0;
            end
        end else if (clken) begin
            if (dec_v[0]) begin
                dsamp <= integ[NS-1];
            end
            for (int k = 0; k < NS; k++) begin
                if (dec_v[k+1]) begin
                    comb[k] <= comb_in[k] - dly[k];
                    dly[k]  <= comb_in[k];
                end
            end
        end
    end

    // Output: top OW bits of the last comb cancel the R^NS DC gain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout <= '0;
        end else if (clken && dec_v[NS+1]) begin
            dout <= out_t'(comb[NS-1][AW-1 -: OW]);
        end
    end

endmodule

// File: rtl/ddc_mix_cic_dec.sv
// Real-to-complex mixer (I = x*cos, Q = -x*sin) followed by a 3-stage CIC
// decimate-by-R on each rail. Both rails share one counter and valid pipe.
module ddc_mix_cic_dec
    import ddc_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clken,
    input  logic                  in_valid,
    input  logic signed [DW-1:0]  data_i,
    input  logic signed [MPR-1:0] fsin_i,
    input  logic signed [MPR-1:0] fcos_i,
    output logic                  out_valid,
    output logic signed [OW-1:0]  fi_o,
    output logic signed [OW-1:0]  fq_o
);

    prod_t            prod_re;
    prod_t            prod_im;
    mix_t             mix_re;
    mix_t             mix_im;
    logic [NS-1:0]    iv;
    logic [NS+1:0]    dv;
    cnt_t             cnt;

    // Full-precision products; Q carries the negated sine term.
    always_comb begin
        prod_re = PW'(data_i) * PW'(fcos_i);
        prod_im = -(PW'(data_i) * PW'(fsin_i));
    end

    // Mixer register with saturation of the single overflowing product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mix_re <= '0;
            mix_im <= '0;
        end else if (clken) begin
            mix_re <= sat_mix(prod_re);
            mix_im <= sat_mix(prod_im);
        end
    end

    // Valid pipe, decimation counter and output strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iv        <= '0;
            dv        <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else if (clken) begin
            iv         <= {iv[NS-2:0], in_valid};
            dv[NS+1:1] <= dv[NS:0];
            dv[0]      <= 1'b0;
            if (iv[NS-1]) begin
                if (cnt == cnt_t'(R - 1)) begin
                    cnt   <= '0;
                    dv[0] <= 1'b1;
                end else begin
                    cnt <= cnt + cnt_t'(1);
                end
            end
            out_valid <= dv[NS+1];
        end
    end

    ddc_cic_chain u_chain_i (
        .clk   (clk),
        .reset (reset),
        .clken (clken),
        .mix   (mix_re),
        .int_v (iv),
        .dec_v (dv),
        .dout  (fi_o)
    );

    ddc_cic_chain u_chain_q (
        .clk   (clk),
        .reset (reset),
        .clken (clken),
        .mix   (mix_im),
        .int_v (iv),
        .dec_v (dv),
        .dout  (fq_o)
    );

endmodule

// File: tb/tb_ddc_mix_cic_dec.sv
// Directed bench for ddc_mix_cic_dec with hand-computed CIC transients.
module tb_ddc_mix_cic_dec;

    logic               clk = 1'b0;
    logic               reset;
    logic               clken;
    logic               in_valid;
    logic signed [13:0] data_i;
    logic signed [13:0] fsin_i;
    logic signed [13:0] fcos_i;
    logic               out_valid;
    logic signed [15:0] fi_o;
    logic signed [15:0] fq_o;

    int checks = 0;
    int errors = 0;

    int                 q_t[$];
    logic signed [15:0] q_i[$];
    logic signed [15:0] q_q[$];

    always #5 clk = ~clk;

    ddc_mix_cic_dec dut (
        .clk       (clk),
        .reset     (reset),
        .clken     (clken),
        .in_valid  (in_valid),
        .data_i    (data_i),
        .fsin_i    (fsin_i),
        .fcos_i    (fcos_i),
        .out_valid (out_valid),
        .fi_o      (fi_o),
        .fq_o      (fq_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        clken    = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_dc();
        data_i = 14'sd8191;
        fcos_i = 14'sd8191;
        fsin_i = 14'sd0;
    endtask

    // Drive n cycles with in_valid every 'period' cycles; log each output strobe.
    task automatic run(input int n, input int period);
        q_t.delete();
        q_i.delete();
        q_q.delete();
        for (int c = 0; c < n; c++) begin
            in_valid = ((c % period) == 0);
            tick();
            if (out_valid) begin
                q_t.push_back(c + 1);
                q_i.push_back(fi_o);
                q_q.push_back(fq_o);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        clken    = 1'b1;
        in_valid = 1'b0;
        data_i   = '0;
        fsin_i   = '0;
        fcos_i   = '0;
        #2;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %0b want 0", out_valid);
        end
        checks++;
        if (fi_o !== 16'sd0 || fq_o !== 16'sd0) begin
            errors++;
            $display("FAIL reset_outputs got fi=%0d fq=%0d want 0 0", fi_o, fq_o);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_dc_i();
        int exp_i[5] = '{7678, 29176, 32760, 32760, 32760};
        do_reset();
        set_dc();
        run(48, 1);
        checks++;
        if (q_t.size() !== 5) begin
            errors++;
            $display("FAIL dc_count got %0d want 5", q_t.size());
        end
        if (q_t.size() > 0) begin
            checks++;
            if (q_t[0] !== 16) begin
                errors++;
                $display("FAIL dc_latency got %0d want 16", q_t[0]);
            end
        end
        for (int k = 0; k < q_t.size() && k < 5; k++) begin
            checks++;
            if (q_i[k] !== 16'(exp_i[k]) || q_q[k] !== 16'sd0) begin
                errors++;
                $display("FAIL dc_value[%0d] got fi=%0d fq=%0d want %0d 0", k, q_i[k], q_q[k], exp_i[k]);
            end
            if (k > 0) begin
                checks++;
                if (q_t[k] - q_t[k-1] !== 8) begin
                    errors++;
                    $display("FAIL dc_spacing[%0d] got %0d want 8", k, q_t[k] - q_t[k-1]);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int exp_i[5] = '{7679, 29183, 32767, 32767, 32767};
        int exp_q[5] = '{-7680, -29184, -32768, -32768, -32768};
        do_reset();
        data_i = -14'sd8192;
        fcos_i = -14'sd8192;
        fsin_i = -14'sd8192;
        run(48, 1);
        checks++;
        if (q_t.size() !== 5) begin
            errors++;
            $display("FAIL sat_count got %0d want 5", q_t.size());
        end
        for (int k = 0; k < q_t.size() && k < 5; k++) begin
            checks++;
            if (q_i[k] !== 16'(exp_i[k]) || q_q[k] !== 16'(exp_q[k])) begin
                errors++;
                $display("FAIL sat_value[%0d] got fi=%0d fq=%0d want %0d %0d",
                         k, q_i[k], q_q[k], exp_i[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_gapped();
        int exp_i[3] = '{7678, 29176, 32760};
        int exp_t[3] = '{30, 54, 78};
        do_reset();
        set_dc();
        run(80, 3);
        checks++;
        if (q_t.size() !== 3) begin
            errors++;
            $display("FAIL gap_count got %0d want 3", q_t.size());
        end
        for (int k = 0; k < q_t.size() && k < 3; k++) begin
            checks++;
            if (q_t[k] !== exp_t[k]) begin
                errors++;
                $display("FAIL gap_time[%0d] got %0d want %0d", k, q_t[k], exp_t[k]);
            end
            checks++;
            if (q_i[k] !== 16'(exp_i[k]) || q_q[k] !== 16'sd0) begin
                errors++;
                $display("FAIL gap_value[%0d] got fi=%0d fq=%0d want %0d 0", k, q_i[k], q_q[k], exp_i[k]);
            end
        end
    endtask

    task automatic test_clken_freeze();
        int found;
        int t_next;
        do_reset();
        set_dc();
        in_valid = 1'b1;
        for (int c = 0; c < 16; c++) tick();
        checks++;
        if (out_valid !== 1'b1 || fi_o !== 16'sd7678) begin
            errors++;
            $display("FAIL frz_pre got v=%0b fi=%0d want 1 7678", out_valid, fi_o);
        end
        clken = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || fi_o !== 16'sd7678 || fq_o !== 16'sd0) begin
                errors++;
                $display("FAIL frz_hold[%0d] got v=%0b fi=%0d fq=%0d want 1 7678 0", c, out_valid, fi_o, fq_o);
            end
        end
        clken  = 1'b1;
        found  = 0;
        t_next = 0;
        for (int c = 1; c <= 20 && found == 0; c++) begin
            tick();
            if (c == 1) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL frz_strobe_drop got %0b want 0", out_valid);
                end
            end
            if (out_valid) begin
                found  = 1;
                t_next = c;
            end
        end
        checks++;
        if (t_next !== 8) begin
            errors++;
            $display("FAIL frz_next_time got %0d want 8", t_next);
        end
        checks++;
        if (fi_o !== 16'sd29176 || fq_o !== 16'sd0) begin
            errors++;
            $display("FAIL frz_next_value got fi=%0d fq=%0d want 29176 0", fi_o, fq_o);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_dc();
        in_valid = 1'b1;
        for (int c = 0; c < 21; c++) tick();
        checks++;
        if (fi_o !== 16'sd7678) begin
            errors++;
            $display("FAIL rmid_pre got fi=%0d want 7678", fi_o);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (fi_o !== 16'sd0 || fq_o !== 16'sd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async got v=%0b fi=%0d fq=%0d want 0 0 0", out_valid, fi_o, fq_o);
        end
        tick();
        reset = 1'b0;
        run(16, 1);
        checks++;
        if (q_t.size() !== 1) begin
            errors++;
            $display("FAIL rmid_count got %0d want 1", q_t.size());
        end else begin
            checks++;
            if (q_t[0] !== 16 || q_i[0] !== 16'sd7678 || q_q[0] !== 16'sd0) begin
                errors++;
                $display("FAIL rmid_first got t=%0d fi=%0d fq=%0d want 16 7678 0", q_t[0], q_i[0], q_q[0]);
            end
        end
    endtask

    task automatic test_wrap();
        int bad_v;
        int bad_t;
        logic signed [15:0] want;
        do_reset();
        set_dc();
        run(10000, 1);
        checks++;
        if (q_t.size() !== 1249) begin
            errors++;
            $display("FAIL wrap_count got %0d want 1249", q_t.size());
        end
        bad_v = 0;
        bad_t = 0;
        for (int k = 0; k < q_t.size(); k++) begin
            want = (k == 0) ? 16'sd7678 : (k == 1) ? 16'sd29176 : 16'sd32760;
            checks++;
            if (q_i[k] !== want || q_q[k] !== 16'sd0) begin
                errors++;
                if (bad_v < 10)
                    $display("FAIL wrap_value[%0d] got fi=%0d fq=%0d want %0d 0", k, q_i[k], q_q[k], want);
                bad_v++;
            end
            if (k > 0) begin
                checks++;
                if (q_t[k] - q_t[k-1] !== 8) begin
                    errors++;
                    if (bad_t < 10)
                        $display("FAIL wrap_spacing[%0d] got %0d want 8", k, q_t[k] - q_t[k-1]);
                    bad_t++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_dc_i();
        test_saturation();
        test_gapped();
        test_clken_freeze();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
